bram_rd_arbiter: RTL and testbench
==================================

BRAM_RD_ARBITER -- requirements
Module: bram_rd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: RAM byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32: RAM read-data width.
REQ-003 SHALL have parameter LEN_W, default 8: burst-length field width, in words.
REQ-004 SHALL have parameter RD_LAT, default 1: RAM read latency in cycles; legal values are 1 and 2.
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1: single clock
- rst_n  in  1: asynchronous, active-low reset
REQ-006 SHALL have the following requester ports, with x = 0 or 1:
- reqx  in  1: read request, held high until granted
- addrx  in  ADDR_W: burst start byte address, word aligned
- lenx  in  LEN_W: burst length in words
- gntx  out  1: one-cycle grant pulse
REQ-007 SHALL have the following RAM ports:
- ram_clk  out  1: equals clk
- ram_en  out  1: read enable
- ram_addr  out  ADDR_W: read byte address
- ram_rd_data  in  DATA_W: read data
- ram_rst  out  1: tied 0
REQ-008 SHALL have the following return ports:
- rd_valid  out  1: rd_data valid
- rd_data  out  DATA_W: ram_rd_data forwarded
- rd_id  out  1: owner of the current beat
- rd_last  out  1: last beat of the burst
- busy  out  1: FSM not in IDLE

Function
REQ-009 SHALL implement FSM states IDLE, ISSUE and DRAIN.
REQ-010 IDLE with any reqx high SHALL, in the same cycle:
- pulse gntx of the winner;
- latch addrx and lenx into cur_addr and remain;
- set owner to x;
- go to ISSUE if lenx != 0, else stay in IDLE with no RAM access and no rd_valid.
REQ-011 ISSUE SHALL, every cycle:
- drive ram_en = 1 and ram_addr = cur_addr;
- then cur_addr += 4 (wraps modulo 2^ADDR_W) and remain -= 1;
- go to DRAIN when remain == 1.
REQ-012 DRAIN SHALL last exactly RD_LAT cycles with ram_en = 0, then return to IDLE.
REQ-013 In each cycle:
- rd_valid SHALL equal ram_en delayed by RD_LAT cycles;
- rd_data SHALL equal ram_rd_data, combinational pass-through;
- rd_id and rd_last SHALL be delayed through the same RD_LAT pipeline.
REQ-014 rd_last SHALL be high only on the beat issued in the final ISSUE cycle.
REQ-015 Latency: grant at cycle T; first ram_en at T+1; first rd_valid at T+1+RD_LAT; burst of N words frees the arbiter at T+1+N+RD_LAT.
REQ-016 A reqx asserted while busy SHALL be ignored until IDLE; gntx SHALL never pulse outside IDLE.
REQ-017 When ram_en = 0, ram_addr SHALL hold its last value.
REQ-018 gnt0 and gnt1 SHALL never be high in the same cycle.
REQ-019 Arbitration with both req high is decided by BRAM_RD_ARB_RR_EN, per REQ-025 and REQ-026.
REQ-020 A requester changing addrx or lenx after its grant SHALL NOT affect the burst in flight.

Reset
REQ-021 On rst_n low, all outputs SHALL go to 0 asynchronously: gnt0, gnt1, ram_en, ram_addr, rd_valid, rd_id, rd_last and busy.
REQ-022 On rst_n low, the FSM SHALL go to IDLE, the RD_LAT pipeline SHALL be cleared, and the round-robin pointer SHALL be reset to favour requester 0.
REQ-023 Reset during ISSUE or DRAIN SHALL abort the burst: no further rd_valid, and no rd_last for the aborted burst.
REQ-024 The first grant SHALL be possible in the first clk edge after rst_n deasserts.

Configuration
REQ-025 With macro BRAM_RD_ARB_RR_EN defined, arbitration SHALL be round-robin: on a tie, the requester not granted last wins; the pointer updates only on a grant.
REQ-026 Without BRAM_RD_ARB_RR_EN, arbitration SHALL be fixed priority: requester 0 always wins a tie, and the pointer logic SHALL be absent.

Verification
REQ-027 Single burst: RD_LAT = 1, req0 with addr0 = 0x100, len0 = 4 -> gnt0 one cycle; ram_addr 0x100, 0x104, 0x108, 0x10C on consecutive cycles; 4 rd_valid with rd_id = 0 and rd_last on the 4th; busy drops 6 cycles after gnt0.
REQ-028 Tie: req0 and req1 both held, len = 2 each.
- With BRAM_RD_ARB_RR_EN: grants go 0, 1, 0, 1.
- Without it: requester 0 is granted every time, and gnt1 only after req0 drops.
REQ-029 Zero-length and wrap: len0 = 0 -> gnt0 pulses, ram_en and rd_valid stay 0, and IDLE holds. addr1 = 0xFFFFFFFC with len1 = 2 -> ram_addr 0xFFFFFFFC then 0x00000000.
REQ-030 RD_LAT = 2, len1 = 3 -> rd_valid trails ram_en by exactly 2 cycles; rd_id = 1; rd_last on the 3rd beat.
REQ-031 Reset mid-burst: len0 = 8, rst_n pulled low after the 3rd ram_en -> all outputs 0 immediately; no rd_last; after release, a new req1 is granted on the first clk edge.
REQ-032 Late request: req1 raised during an active burst on requester 0 -> gnt1 only in the IDLE cycle after DRAIN completes; addr1 changed after gnt1 -> ram_addr unchanged.

Source files
------------

// File: rtl/bram_rd_arbiter_if.sv
// Bus bundle between two burst-read requesters, the block RAM read port and
// the read-return stream.
//   requesters : req0/1, addr0/1, len0/1 in; gnt0/1 out
//   ram        : ram_clk, ram_en, ram_addr, ram_rst out; ram_rd_data in
//   return     : rd_valid, rd_data, rd_id, rd_last, busy out
// Modports: slave = arbiter side, master = requesters/RAM/consumer side.
interface bram_rd_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 8
) ();

  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic [LEN_W-1:0]  len0;
  logic              gnt0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic [LEN_W-1:0]  len1;
  logic              gnt1;

  logic              ram_clk;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rd_data;
  logic              ram_rst;

  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_id;
  logic              rd_last;
  logic              busy;

  modport slave (
    input  req0, addr0, len0, req1, addr1, len1, ram_rd_data,
    output gnt0, gnt1, ram_clk, ram_en, ram_addr, ram_rst,
    output rd_valid, rd_data, rd_id, rd_last, busy
  );

  modport master (
    output req0, addr0, len0, req1, addr1, len1, ram_rd_data,
    input  gnt0, gnt1, ram_clk, ram_en, ram_addr, ram_rst,
    input  rd_valid, rd_data, rd_id, rd_last, busy
  );

endinterface

// File: rtl/bram_rd_arbiter.sv
// Two-requester burst-read arbiter in front of a block RAM read port.
// A grant is a combinational pulse in IDLE; the burst is then issued one word
// per cycle (byte address += 4) and the return sideband (valid/id/last) is
// delayed by RD_LAT to line up with the RAM read data.
// Ports:
//   clk   : single clock (also forwarded as bus.ram_clk)
//   rst_n : asynchronous active-low reset
//   bus   : bram_rd_arbiter_if.slave (requesters, RAM port, return stream)
// Option: define BRAM_RD_ARB_RR_EN for round-robin tie break; otherwise
// requester 0 has fixed priority.
module bram_rd_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  bram_rd_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [ADDR_W-1:0] last_addr_q;
  logic [LEN_W-1:0]  remain_q;
  logic              owner_q;
  logic              drain_cnt_q;

  logic              req_any, win1, grant, issue, issue_last;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic [DATA_W-1:0] rd_data_w;

  logic [RD_LAT-1:0] vld_q, id_q, last_q;

  assign req_any    = bus.req0 | bus.req1;
  // Gated by rst_n so the grant pulse is also forced low while in reset.
  assign grant      = rst_n & (state_q == StIdle) & req_any;
  assign sel_addr   = win1 ? bus.addr1 : bus.addr0;
  assign sel_len    = win1 ? bus.len1 : bus.len0;
  assign issue      = (state_q == StIssue);
  assign issue_last = issue && (remain_q == LEN_W'(1));

`ifdef BRAM_RD_ARB_RR_EN
  logic prio_last_q;  // requester granted most recently

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_last_q <= 1'b1;  // so requester 0 wins the first tie
    end else if (grant) begin
      prio_last_q <= win1;
    end
  end

  assign win1 = bus.req1 & (~bus.req0 | ~prio_last_q);
`else
  assign win1 = bus.req1 & ~bus.req0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant && (sel_len != '0)) state_d = StIssue;
      StIssue: if (remain_q == LEN_W'(1)) state_d = StDrain;
      StDrain: if (!drain_cnt_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    bus.gnt0     = grant & ~win1;
    bus.gnt1     = grant & win1;
    bus.ram_en   = issue;
    // Outside ISSUE the address holds the last word issued.
    bus.ram_addr = issue ? cur_addr_q : last_addr_q;
    bus.busy     = (state_q != StIdle);
  end

  // Burst bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr_q  <= '0;
      last_addr_q <= '0;
      remain_q    <= '0;
      owner_q     <= 1'b0;
      drain_cnt_q <= 1'b0;
    end else begin
      if (grant) begin
        cur_addr_q <= sel_addr;
        remain_q   <= sel_len;
        owner_q    <= win1;
      end else if (issue) begin
        cur_addr_q  <= cur_addr_q + ADDR_W'(4);
        remain_q    <= remain_q - LEN_W'(1);
        last_addr_q <= cur_addr_q;
      end
      // Counts the DRAIN cycles still to go after the current one.
      if (issue) begin
        drain_cnt_q <= 1'(RD_LAT - 1);
      end else if ((state_q == StDrain) && drain_cnt_q) begin
        drain_cnt_q <= 1'b0;
      end
    end
  end

  // Return sideband pipeline, RD_LAT stages deep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      id_q   <= '0;
      last_q <= '0;
    end else begin
      vld_q  <= RD_LAT'({vld_q, issue});
      id_q   <= RD_LAT'({id_q, owner_q});
      last_q <= RD_LAT'({last_q, issue_last});
    end
  end

  assign rd_data_w    = bus.ram_rd_data;
  assign bus.rd_data  = rd_data_w;
  assign bus.rd_valid = vld_q[RD_LAT-1];
  assign bus.rd_id    = id_q[RD_LAT-1];
  assign bus.rd_last  = last_q[RD_LAT-1];
  assign bus.ram_clk  = clk;
  assign bus.ram_rst  = 1'b0;

endmodule

// File: tb/tb_bram_rd_arbiter.sv
// Directed bench for bram_rd_arbiter: one instance with RD_LAT=1 and one with
// RD_LAT=2, each on its own interface, sharing clock and reset.
module tb_bram_rd_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  bram_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) if1 ();
  bram_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) if2 ();

  bram_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .LEN_W(8), .RD_LAT(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  bram_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .LEN_W(8), .RD_LAT(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Next mid-cycle sample of the RD_LAT=1 instance.
  task automatic step1(input string tag, input logic en, input logic [31:0] addr,
                       input logic vld, input logic id, input logic last, input logic bsy);
    @(negedge clk);
    check_eq({tag, ".en"}, if1.ram_en, en);
    check_eq({tag, ".addr"}, if1.ram_addr, addr);
    check_eq({tag, ".vld"}, if1.rd_valid, vld);
    if (vld) check_eq({tag, ".id"}, if1.rd_id, id);
    check_eq({tag, ".last"}, if1.rd_last, last);
    check_eq({tag, ".busy"}, if1.busy, bsy);
  endtask

  task automatic step2(input string tag, input logic en, input logic [31:0] addr,
                       input logic vld, input logic id, input logic last, input logic bsy);
    @(negedge clk);
    check_eq({tag, ".en"}, if2.ram_en, en);
    check_eq({tag, ".addr"}, if2.ram_addr, addr);
    check_eq({tag, ".vld"}, if2.rd_valid, vld);
    if (vld) check_eq({tag, ".id"}, if2.rd_id, id);
    check_eq({tag, ".last"}, if2.rd_last, last);
    check_eq({tag, ".busy"}, if2.busy, bsy);
  endtask

  // Waits for a grant on if1; who = -1 when the bound expires.
  task automatic wait_grant(output int who);
    who = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check_eq("gnt_excl", 64'(if1.gnt0 & if1.gnt1), 64'd0);
      if (if1.gnt0 || if1.gnt1) begin
        who = if1.gnt1 ? 1 : 0;
        break;
      end
    end
  endtask

  task automatic wait_idle1;
    int n;
    n = 0;
    while (if1.busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_bound", 64'(if1.busy), 64'd0);
  endtask

  initial begin
    int who;
    n_checks = 0;
    n_errors = 0;
    if1.req0 = 1'b0; if1.addr0 = '0; if1.len0 = '0;
    if1.req1 = 1'b0; if1.addr1 = '0; if1.len1 = '0;
    if1.ram_rd_data = 32'hDEADBEEF;
    if2.req0 = 1'b0; if2.addr0 = '0; if2.len0 = '0;
    if2.req1 = 1'b0; if2.addr1 = '0; if2.len1 = '0;
    if2.ram_rd_data = '0;
    rst_n = 1'b0;

    // Reset state, with a request held to show gnt is masked
    if1.req0 = 1'b1;
    #3;
    check_eq("rst.gnt0", if1.gnt0, 1'b0);
    check_eq("rst.busy", if1.busy, 1'b0);
    check_eq("rst.en", if1.ram_en, 1'b0);
    check_eq("rst.addr", if1.ram_addr, 32'h0);
    check_eq("rst.vld", if1.rd_valid, 1'b0);
    check_eq("rst.rst", if1.ram_rst, 1'b0);
    check_eq("rst.data", if1.rd_data, 32'hDEADBEEF);
    if1.req0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Tie, both held, len 2 each
    @(posedge clk); #1;
    if1.req0 = 1'b1; if1.addr0 = 32'h200; if1.len0 = 8'd2;
    if1.req1 = 1'b1; if1.addr1 = 32'h300; if1.len1 = 8'd2;
    for (int g = 0; g < 4; g++) begin
      wait_grant(who);
`ifdef BRAM_RD_ARB_RR_EN
      check_eq($sformatf("tie%0d", g), 64'(who), 64'(g % 2));
`else
      check_eq($sformatf("tie%0d", g), 64'(who), 64'd0);
`endif
    end
    @(posedge clk); #1;
    if1.req0 = 1'b0;
`ifndef BRAM_RD_ARB_RR_EN
    wait_grant(who);
    check_eq("tie_after_drop", 64'(who), 64'd1);
    @(posedge clk); #1;
`endif
    if1.req1 = 1'b0;
    wait_idle1();

    // Single burst 0x100 x4
    @(posedge clk); #1;
    if1.req0 = 1'b1; if1.addr0 = 32'h100; if1.len0 = 8'd4;
    if1.ram_rd_data = 32'h12345678;
    @(negedge clk);
    check_eq("sb.gnt0", if1.gnt0, 1'b1);
    check_eq("sb.gnt1", if1.gnt1, 1'b0);
    check_eq("sb.data", if1.rd_data, 32'h12345678);
    @(posedge clk); #1;
    if1.req0 = 1'b0;
    step1("sb1", 1, 32'h100, 0, 0, 0, 1);
    step1("sb2", 1, 32'h104, 1, 0, 0, 1);
    step1("sb3", 1, 32'h108, 1, 0, 0, 1);
    step1("sb4", 1, 32'h10C, 1, 0, 0, 1);
    step1("sb5", 0, 32'h10C, 1, 0, 1, 1);
    step1("sb6", 0, 32'h10C, 0, 0, 0, 0);

    // Zero length: grant only, address holds
    @(posedge clk); #1;
    if1.req0 = 1'b1; if1.addr0 = 32'h800; if1.len0 = 8'd0;
    @(negedge clk);
    check_eq("z.gnt0", if1.gnt0, 1'b1);
    @(posedge clk); #1;
    if1.req0 = 1'b0;
    step1("z1", 0, 32'h10C, 0, 0, 0, 0);
    step1("z2", 0, 32'h10C, 0, 0, 0, 0);

    // Address wrap on requester 1
    @(posedge clk); #1;
    if1.req1 = 1'b1; if1.addr1 = 32'hFFFFFFFC; if1.len1 = 8'd2;
    @(negedge clk);
    check_eq("w.gnt1", if1.gnt1, 1'b1);
    @(posedge clk); #1;
    if1.req1 = 1'b0;
    step1("w1", 1, 32'hFFFFFFFC, 0, 1, 0, 1);
    step1("w2", 1, 32'h00000000, 1, 1, 0, 1);
    step1("w3", 0, 32'h00000000, 1, 1, 1, 1);
    step1("w4", 0, 32'h00000000, 0, 1, 0, 0);

    // Late request on 1 during a burst on 0, then addr1 changed after grant
    @(posedge clk); #1;
    if1.req0 = 1'b1; if1.addr0 = 32'h400; if1.len0 = 8'd3;
    @(negedge clk);
    check_eq("late.gnt0", if1.gnt0, 1'b1);
    @(posedge clk); #1;
    if1.req0 = 1'b0;
    if1.req1 = 1'b1; if1.addr1 = 32'h500; if1.len1 = 8'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq($sformatf("late.nogrant%0d", i), if1.gnt1, 1'b0);
    end
    @(negedge clk);
    check_eq("late.gnt1", if1.gnt1, 1'b1);
    @(posedge clk); #1;
    if1.req1 = 1'b0; if1.addr1 = 32'h900; if1.len1 = 8'd5;
    step1("late1", 1, 32'h500, 0, 1, 0, 1);
    step1("late2", 0, 32'h500, 1, 1, 1, 1);
    step1("late3", 0, 32'h500, 0, 1, 0, 0);

    // RD_LAT = 2 instance, requester 1, len 3
    @(posedge clk); #1;
    if2.req1 = 1'b1; if2.addr1 = 32'h700; if2.len1 = 8'd3;
    @(negedge clk);
    check_eq("l2.gnt1", if2.gnt1, 1'b1);
    @(posedge clk); #1;
    if2.req1 = 1'b0;
    step2("l2_1", 1, 32'h700, 0, 1, 0, 1);
    step2("l2_2", 1, 32'h704, 0, 1, 0, 1);
    step2("l2_3", 1, 32'h708, 1, 1, 0, 1);
    step2("l2_4", 0, 32'h708, 1, 1, 0, 1);
    step2("l2_5", 0, 32'h708, 1, 1, 1, 1);
    step2("l2_6", 0, 32'h708, 0, 1, 0, 0);

    // Reset mid-burst
    @(posedge clk); #1;
    if1.req0 = 1'b1; if1.addr0 = 32'h600; if1.len0 = 8'd8;
    @(negedge clk);
    check_eq("rm.gnt0", if1.gnt0, 1'b1);
    @(posedge clk); #1;
    if1.req0 = 1'b0;
    step1("rm1", 1, 32'h600, 0, 0, 0, 1);
    step1("rm2", 1, 32'h604, 1, 0, 0, 1);
    step1("rm3", 1, 32'h608, 1, 0, 0, 1);
    @(posedge clk); #1;
    if1.req1 = 1'b1; if1.addr1 = 32'hA00; if1.len1 = 8'd1;
    rst_n = 1'b0;
    #1;
    check_eq("rm.rst.en", if1.ram_en, 1'b0);
    check_eq("rm.rst.addr", if1.ram_addr, 32'h0);
    check_eq("rm.rst.vld", if1.rd_valid, 1'b0);
    check_eq("rm.rst.last", if1.rd_last, 1'b0);
    check_eq("rm.rst.id", if1.rd_id, 1'b0);
    check_eq("rm.rst.busy", if1.busy, 1'b0);
    check_eq("rm.rst.gnt1", if1.gnt1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rm.rel.gnt1", if1.gnt1, 1'b1);
    check_eq("rm.rel.vld", if1.rd_valid, 1'b0);
    @(posedge clk); #1;
    if1.req1 = 1'b0;
    step1("rm4", 1, 32'hA00, 0, 1, 0, 1);
    step1("rm5", 0, 32'hA00, 1, 1, 1, 1);
    step1("rm6", 0, 32'hA00, 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
